// File: rtl/cpu_pkg.sv
// Types and constants shared across the CPU front end.
package cpu_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] PC_INC        = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction that returns while decode is stalled.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic        i_clr,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= 32'd0;
            r_pc    <= 32'd0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single outstanding imem request, stall skid, redirect handling.
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instruction_IF,
    output logic [31:0] pc_IF,
    output logic        stall_out,
    output logic        flush_out
);
    fetch_state_e r_state;
    logic         r_req;
    logic [31:0]  r_addr;
    logic [31:0]  r_tgt;
    logic         r_valid;
    logic [31:0]  r_instr;
    logic [31:0]  r_pc;

    logic         w_ack;
    logic [31:0]  w_redir_pc;
    logic [31:0]  w_next_addr;
    logic         w_skid_load;
    logic         w_skid_clr;
    logic         w_skid_vld;
    logic [31:0]  w_skid_instr;
    logic [31:0]  w_skid_pc;

    assign w_ack       = imem_ack & r_req;
    assign w_redir_pc  = align_pc(redirect_pc);
    assign w_next_addr = r_addr + PC_INC;
    assign w_skid_load = (r_state == ST_FETCH) & stall_in & w_ack & ~redirect_valid;
    // Draining an empty skid is harmless, so clear on every unstalled FETCH cycle.
    assign w_skid_clr  = redirect_valid | ((r_state == ST_FETCH) & ~stall_in);

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clr   (w_skid_clr),
        .i_instr (imem_rdata),
        .i_pc    (r_addr),
        .o_valid (w_skid_vld),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_addr  <= RESET_PC;
            r_tgt   <= RESET_PC;
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= 32'd0;
        end else if (redirect_valid) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_req   <= 1'b1;
            // An unanswered request must still be retired before the target goes out.
            if (r_req && !imem_ack) begin
                r_state <= ST_DROP;
                r_tgt   <= w_redir_pc;
            end else begin
                r_state <= ST_FETCH;
                r_addr  <= w_redir_pc;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                end
                ST_FETCH: begin
                    if (stall_in) begin
                        if (w_ack) begin
                            r_req  <= 1'b0;
                            r_addr <= w_next_addr;
                        end
                    end else if (w_skid_vld) begin
                        r_instr <= w_skid_instr;
                        r_pc    <= w_skid_pc;
                        r_valid <= 1'b1;
                        r_req   <= 1'b1;
                    end else if (w_ack) begin
                        r_instr <= imem_rdata;
                        r_pc    <= r_addr;
                        r_valid <= 1'b1;
                        r_addr  <= w_next_addr;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                ST_DROP: begin
                    if (w_ack) begin
                        r_state <= ST_FETCH;
                        r_addr  <= r_tgt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign imem_req       = r_req;
    assign imem_addr      = r_addr;
    assign instr_valid    = r_valid;
    assign instruction_IF = r_instr;
    assign pc_IF          = r_pc;
    assign stall_out      = stall_in & ~redirect_valid;
    assign flush_out      = redirect_valid;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed + randomized bench for fetch_ctrl against an in-order instruction-stream model.
module tb_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, stall_in, redirect_valid, imem_ack;
    logic [31:0] redirect_pc, imem_rdata;
    logic        imem_req, instr_valid, stall_out, flush_out;
    logic [31:0] imem_addr, instruction_IF, pc_IF;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_cons  = 0;
    logic [31:0] exp_pc  = RESET_PC;
    logic [31:0] t_a;
    logic        p_req, p_ack, p_rst, p_redir;
    logic [31:0] p_addr;

    fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instruction_IF(instruction_IF), .pc_IF(pc_IF),
        .stall_out(stall_out), .flush_out(flush_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always_comb imem_rdata = imem_ack ? memf(imem_addr) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc);
        chkb({tag, "_vld"}, instr_valid, 1'b1);
        chk({tag, "_pc"}, pc_IF, pc);
        chk({tag, "_instr"}, instruction_IF, memf(pc));
    endtask

    task automatic chk_fetch(input string tag, input logic req, input logic [31:0] addr);
        chkb({tag, "_req"}, imem_req, req);
        chk({tag, "_addr"}, imem_addr, addr);
    endtask

    // One clock: check combinational outputs and the delivered stream, then advance.
    task automatic cyc();
        #1;
        chkb("stall_out", stall_out, stall_in & ~redirect_valid);
        chkb("flush_out", flush_out, redirect_valid);
        if (!rst_n) exp_pc = RESET_PC;
        else if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
        else if (instr_valid && !stall_in) begin
            chk("stream_pc", pc_IF, exp_pc);
            chk("stream_instr", instruction_IF, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_cons++;
        end
        p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
        p_rst = rst_n; p_redir = redirect_valid;
        @(posedge clk);
        #1;
        if (!p_rst) begin
            chk_fetch("rst", 1'b0, RESET_PC);
            chkb("rst_vld", instr_valid, 1'b0);
            chk("rst_instr", instruction_IF, NOP);
            chk("rst_pc", pc_IF, 32'd0);
        end else begin
            if (p_req && !p_ack) chk_fetch("req_hold", 1'b1, p_addr);
            if (p_redir) begin
                chkb("redir_vld", instr_valid, 1'b0);
                chk("redir_nop", instruction_IF, NOP);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; stall_in = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'd0; imem_ack = 1'b0;
        cyc(); cyc();

        // zero-wait stream; ack while req is still low must be ignored
        rst_n = 1'b1; imem_ack = 1'b1;
        cyc();
        chk_fetch("zw_first", 1'b1, 32'h0);
        chkb("zw_v0", instr_valid, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk_fetch("zw", 1'b1, 32'(4 * k));
            chk_out("zw", 32'(4 * (k - 1)));
        end

        // three-cycle memory latency
        imem_ack = 1'b0;
        for (int n = 0; n < 2; n++) begin
            t_a = 32'h10 + 32'(4 * n);
            chk_fetch("lat_c1", 1'b1, t_a); cyc();
            chk_fetch("lat_c2", 1'b1, t_a); chkb("lat_v2", instr_valid, 1'b0); cyc();
            chk_fetch("lat_c3", 1'b1, t_a); chkb("lat_v3", instr_valid, 1'b0);
            imem_ack = 1'b1; cyc();
            chk_out("lat_out", t_a); chk_fetch("lat_nxt", 1'b1, t_a + 32'd4);
            imem_ack = 1'b0;
        end

        // stall window of 4 cycles with an ack inside it
        stall_in = 1'b1; cyc();
        chk_out("stl_frz_b", 32'h14); chk_fetch("stl_wait", 1'b1, 32'h18);
        imem_ack = 1'b1; cyc();
        chk_out("stl_frz_c", 32'h14); chkb("stl_noreq_c", imem_req, 1'b0);
        cyc();
        chk_out("stl_frz_d", 32'h14); chkb("stl_noreq_d", imem_req, 1'b0);
        imem_ack = 1'b0; cyc();
        chk_out("stl_frz_e", 32'h14); chkb("stl_noreq_e", imem_req, 1'b0);
        stall_in = 1'b0; cyc();
        chk_out("stl_skid", 32'h18); chk_fetch("stl_resume", 1'b1, 32'h1C);

        // redirect with a request outstanding
        cyc();
        chkb("rd_idle_v", instr_valid, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        #1 chkb("rd_flush", flush_out, 1'b1);
        cyc();
        redirect_valid = 1'b0;
        chk_fetch("rd_drop", 1'b1, 32'h1C);
        imem_ack = 1'b1; cyc();
        chk_fetch("rd_tgt", 1'b1, 32'h100); chkb("rd_disc", instr_valid, 1'b0);
        cyc();
        chk_out("rd_first", 32'h100); chk_fetch("rd_seq", 1'b1, 32'h104);

        // two redirects while draining: latest wins
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h40; cyc();
        chk_fetch("dd_drop1", 1'b1, 32'h104);
        redirect_pc = 32'h83; cyc();
        chk_fetch("dd_drop2", 1'b1, 32'h104);
        redirect_valid = 1'b0; imem_ack = 1'b1; cyc();
        chk_fetch("dd_tgt", 1'b1, 32'h80);

        // redirect in the same cycle as an ack
        cyc();
        chk_out("ra_pre", 32'h80);
        redirect_valid = 1'b1; redirect_pc = 32'h300; cyc();
        chk_fetch("ra_tgt", 1'b1, 32'h300); chkb("ra_disc", instr_valid, 1'b0);
        redirect_valid = 1'b0; cyc();
        chk_out("ra_first", 32'h300);

        // redirect while stalled with a full skid
        stall_in = 1'b1; cyc();
        chkb("rs_noreq", imem_req, 1'b0);
        imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h400;
        #1 chkb("rs_stall_out", stall_out, 1'b0);
        cyc();
        chk_fetch("rs_tgt", 1'b1, 32'h400); chkb("rs_v", instr_valid, 1'b0);
        redirect_valid = 1'b0; stall_in = 1'b0; cyc();
        chkb("rs_skid_gone", instr_valid, 1'b0); chk_fetch("rs_hold", 1'b1, 32'h400);
        imem_ack = 1'b1; cyc();
        chk_out("rs_first", 32'h400);

        // address wrap, then reset mid-request
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; cyc();
        chk_fetch("wr_top", 1'b1, 32'hFFFF_FFFC);
        redirect_valid = 1'b0; cyc();
        chk_out("wr_out", 32'hFFFF_FFFC); chk_fetch("wr_wrap", 1'b1, 32'h0);
        imem_ack = 1'b0; cyc();
        chk_fetch("wr_pend", 1'b1, 32'h0);
        rst_n = 1'b0; imem_ack = 1'b1; cyc();
        chk_fetch("mr_rst", 1'b0, RESET_PC); chkb("mr_v", instr_valid, 1'b0);
        rst_n = 1'b1; cyc();
        chk_fetch("mr_restart", 1'b1, RESET_PC); chkb("mr_late_ack", instr_valid, 1'b0);
        cyc();
        chk_out("mr_first", RESET_PC);

        // randomized traffic against the stream model
        for (int i = 0; i < 3000; i++) begin
            rst_n          = ($urandom_range(0, 199) != 0);
            stall_in       = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ?
                             (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
            imem_ack       = ($urandom_range(0, 1) == 1);
            cyc();
        end
        chkb("liveness", n_cons > 300, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013, meaning the bubble instruction (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 SHALL have port stall_in  input  1  meaning decode cannot accept a new instruction.
REQ-006 SHALL have ports redirect_valid  input  1  and redirect_pc  input  32, meaning a branch/jump target from EX.
REQ-007 SHALL have ports imem_req  output  1  and imem_addr  output  32, meaning the instruction-memory request and its word address.
REQ-008 SHALL have ports imem_ack  input  1  and imem_rdata  input  32, meaning the memory response, valid only when imem_ack=1.
REQ-009 SHALL have ports instr_valid  output  1, instruction_IF  output  32  and pc_IF  output  32, driven to the IF/ID buffer.
REQ-010 SHALL have ports stall_out  output  1  and flush_out  output  1, driven to the IF/ID buffer stall and flush inputs.

Function
REQ-011 SHALL implement the states IDLE, FETCH and DROP.
REQ-012 SHALL move IDLE->FETCH on the first cycle after reset release.
REQ-013 SHALL hold imem_req high and imem_addr stable until imem_ack, with at most one request outstanding.
REQ-014 SHALL ignore imem_ack while imem_req=0.
REQ-015 SHALL, on an ack in FETCH with no stall and no redirect, register imem_rdata to instruction_IF and imem_addr to pc_IF, set instr_valid=1 on the next cycle, and present addr+4 on imem_addr in that same next cycle with imem_req still high; a zero-wait memory therefore sustains 1 instruction/cycle.
REQ-016 SHALL, while stall_in=1, hold instruction_IF, pc_IF and instr_valid unchanged.
REQ-017 SHALL, while stall_in=1, capture an ack arriving for the outstanding request into a 1-entry skid register and issue no new request while the skid is full.
REQ-018 SHALL, when stall_in falls, move the skid entry to the outputs on the next cycle and resume requests at the following address.
REQ-019 SHALL drive stall_out = stall_in & ~redirect_valid combinationally.
REQ-020 SHALL drive flush_out = redirect_valid combinationally, in the same cycle.
REQ-021 SHALL give redirect_valid priority over stall_in and acks.
REQ-022 SHALL, on a redirect: set instr_valid=0 and instruction_IF=NOP_INSTR the next cycle, clear the skid, and load the fetch PC with {redirect_pc[31:2],2'b00}.
REQ-023 SHALL, on a redirect with a request outstanding and no ack in that cycle, enter DROP: imem_req stays high with the old address, the eventual ack data is discarded, and the next cycle requests the redirect PC in FETCH.
REQ-024 SHALL, on a redirect in the same cycle as an ack, discard that data and request the redirect PC next cycle.
REQ-025 SHALL, on a further redirect while in DROP, use the latest redirect_pc.
REQ-026 SHALL compute PC increment modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.

Reset
REQ-027 SHALL, while rst_n=0 at a clk edge, set state=IDLE, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruction_IF=NOP_INSTR, pc_IF=0, and clear the skid.
REQ-028 SHALL, on reset during an outstanding request, abandon the request, ignore any late ack, and restart from RESET_PC.

Structure
REQ-029 SHALL take the state enum type, NOP_INSTR default and the PC increment constant (4) from the shared package cpu_pkg.
REQ-030 SHALL instantiate one sub-module, fetch_skid_buf (1-entry data/pc/valid register with load/clear), inside fetch_ctrl.

Verification
REQ-031 SHALL cover zero-wait stream: ack every cycle from reset -> imem_addr 0,4,8,C on consecutive cycles; pc_IF follows one cycle later with instr_valid=1.
REQ-032 SHALL cover 3-cycle memory latency: ack on the 3rd request cycle -> imem_addr held 3 cycles; instr_valid pulses 1 cycle per instruction.
REQ-033 SHALL cover stall: stall_in high 4 cycles with an ack arriving inside the window -> outputs frozen, imem_req low after the ack, skid instruction appears the cycle after release.
REQ-034 SHALL cover redirect with a request outstanding: redirect_pc=32'h0000_0103 while waiting -> flush_out=1 that cycle, old data discarded, next imem_addr=32'h0000_0100.
REQ-035 SHALL cover redirect+ack same cycle and redirect during stall -> data dropped, stall_out=0, instr_valid=0, next fetch at target.
REQ-036 SHALL cover wrap and reset: fetch from 32'hFFFF_FFFC -> next address 0; rst_n low mid-request -> all outputs at reset values, fetch restarts at RESET_PC.
